// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC helpers for the CCFF bitstream loader.
// CRC constants are only consumed when CCFF_READBACK_EN is defined.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    VERIFY,
    DONE
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial step of a non-reflected CRC-8, MSB-first register.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8, one bit per clock; clr has priority over en.
module ccff_crc8
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_reg;
  logic [7:0] crc_next;

  always_comb begin
    crc_next = crc_reg;
    if (clr) begin
      crc_next = CRC8_INIT;
    end else if (en) begin
      crc_next = crc8_step(crc_reg, din);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      crc_reg <= CRC8_INIT;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words LSB-first into a CCFF configuration chain.
// Define CCFF_READBACK_EN to add a CRC-checked recirculating VERIFY pass.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter  int CHAIN_LEN = 64,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic              error
);

  localparam int LEFT_W = $clog2(WORD_W + 1);

  state_t              state_reg;
  logic [WORD_W-1:0]   word_reg;
  logic [CNT_W-1:0]    bit_count_reg;
  logic [LEFT_W-1:0]   left_reg;
  logic                head_reg;
  logic                shift_en_reg;
  logic                ready_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [CNT_W-1:0]    remaining;
  logic [LEFT_W-1:0]   first_left;

  // Bits still owed to the chain decide how much of the next word is used.
  assign remaining = CNT_W'(CHAIN_LEN) - bit_count_reg;

  always_comb begin
    first_left = LEFT_W'(WORD_W - 1);
    if (32'(remaining) < WORD_W) begin
      first_left = LEFT_W'(remaining) - LEFT_W'(1);
    end
  end

`ifdef CCFF_READBACK_EN
  logic [1:0]       crc_en;
  logic [1:0]       crc_din;
  logic [7:0]       crc_val [2];
  logic             crc_clr;
  logic [CNT_W-1:0] vcnt_reg;
  logic             error_reg;

  assign crc_clr    = (state_reg == IDLE) && start;
  assign crc_en[0]  = (state_reg == SHIFT);
  assign crc_din[0] = head_reg;
  assign crc_en[1]  = (state_reg == VERIFY);
  assign crc_din[1] = ccff_tail;

  // Instance 0 digests what was written, instance 1 what came back.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_crc
      ccff_crc8 u_crc (
        .clk  (prog_clk),
        .srst (prog_reset),
        .clr  (crc_clr),
        .en   (crc_en[gi]),
        .din  (crc_din[gi]),
        .crc  (crc_val[gi])
      );
    end
  endgenerate

  assign ccff_head = (state_reg == VERIFY) ? ccff_tail : head_reg;
  assign error     = error_reg;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign ccff_head   = head_reg;
  assign error       = 1'b0;
`endif

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_reg     <= IDLE;
      word_reg      <= '0;
      bit_count_reg <= '0;
      left_reg      <= '0;
      head_reg      <= 1'b0;
      shift_en_reg  <= 1'b0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef CCFF_READBACK_EN
      vcnt_reg      <= '0;
      error_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= LOAD;
            bit_count_reg <= '0;
            busy_reg      <= 1'b1;
            ready_reg     <= 1'b1;
`ifdef CCFF_READBACK_EN
            error_reg     <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (word_valid) begin
            word_reg      <= word_data >> 1;
            head_reg      <= word_data[0];
            shift_en_reg  <= 1'b1;
            bit_count_reg <= bit_count_reg + CNT_W'(1);
            left_reg      <= first_left;
            ready_reg     <= 1'b0;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          if (left_reg == '0) begin
            shift_en_reg <= 1'b0;
            if (bit_count_reg == CNT_W'(CHAIN_LEN)) begin
`ifdef CCFF_READBACK_EN
              state_reg    <= VERIFY;
              shift_en_reg <= 1'b1;
              vcnt_reg     <= CNT_W'(CHAIN_LEN - 1);
`else
              state_reg    <= DONE;
              done_reg     <= 1'b1;
              busy_reg     <= 1'b0;
`endif
            end else begin
              state_reg <= LOAD;
              ready_reg <= 1'b1;
            end
          end else begin
            head_reg      <= word_reg[0];
            word_reg      <= word_reg >> 1;
            bit_count_reg <= bit_count_reg + CNT_W'(1);
            left_reg      <= left_reg - LEFT_W'(1);
          end
        end
`ifdef CCFF_READBACK_EN
        VERIFY: begin
          if (vcnt_reg == '0) begin
            // Fold the final tail sample in before comparing.
            error_reg    <= (crc_val[0] != crc8_step(crc_val[1], ccff_tail));
            shift_en_reg <= 1'b0;
            state_reg    <= DONE;
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            vcnt_reg <= vcnt_reg - CNT_W'(1);
          end
        end
`endif
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign word_ready    = ready_reg;
  assign ccff_shift_en = shift_en_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign bit_count     = bit_count_reg;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (64-cell and 10-cell chains),
// each feeding a behavioural chain model clocked by ccff_shift_en.
module tb_ccff_bitstream_loader;

`ifdef CCFF_READBACK_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       start [2];
  logic       valid [2];
  logic [7:0] data  [2];
  logic       tail  [2];
  logic       flip  [2];
  logic       ready [2];
  logic       head  [2];
  logic       sen   [2];
  logic       busy  [2];
  logic       done  [2];
  logic       err   [2];
  logic [6:0] bc0;
  logic [3:0] bc1;

  ccff_bitstream_loader #(.CHAIN_LEN(64), .WORD_W(8)) dut0 (
    .prog_clk(clk), .prog_reset(rst[0]), .start(start[0]), .word_valid(valid[0]),
    .word_data(data[0]), .word_ready(ready[0]), .ccff_head(head[0]),
    .ccff_shift_en(sen[0]), .ccff_tail(tail[0]), .busy(busy[0]), .done(done[0]),
    .bit_count(bc0), .error(err[0]));

  ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut1 (
    .prog_clk(clk), .prog_reset(rst[1]), .start(start[1]), .word_valid(valid[1]),
    .word_data(data[1]), .word_ready(ready[1]), .ccff_head(head[1]),
    .ccff_shift_en(sen[1]), .ccff_tail(tail[1]), .busy(busy[1]), .done(done[1]),
    .bit_count(bc1), .error(err[1]));

  // Chain model: newest bit at [0], tail at the top cell.
  logic [63:0] chain0 = '0;
  logic [9:0]  chain1 = '0;
  int          shifts [2] = '{0, 0};

  assign tail[0] = chain0[63] ^ flip[0];
  assign tail[1] = chain1[9]  ^ flip[1];

  always @(posedge clk) begin
    if (sen[0] === 1'b1) begin
      chain0    <= {chain0[62:0], head[0]};
      shifts[0] <= shifts[0] + 1;
    end
    if (sen[1] === 1'b1) begin
      chain1    <= {chain1[8:0], head[1]};
      shifts[1] <= shifts[1] + 1;
    end
  end

  int nvec = 0;
  int nbad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic int bc(input int k);
    return (k == 0) ? int'(bc0) : int'(bc1);
  endfunction

  function automatic int clen(input int k);
    return (k == 0) ? 64 : 10;
  endfunction

  typedef struct {
    int         k;
    logic [7:0] w [8];
    int         g [8];
    int         pulse_at;
    int         flip_at;
    int         exp_cyc;
    bit         exp_err;
  } vec_t;

  // Reference: each used word costs its wait cycles, one accept cycle and
  // as many shift cycles as bits it contributes; readback adds one chain pass.
  function automatic int model_cycles(input vec_t v);
    int used, n, cyc, i;
    used = 0; cyc = 1; i = 0;
    while (used < clen(v.k)) begin
      n = (clen(v.k) - used < 8) ? clen(v.k) - used : 8;
      cyc += v.g[i] + 1 + n;
      used += n;
      i++;
    end
    return cyc + (VER ? clen(v.k) : 0);
  endfunction

  // Reference chain image: stream bit i ends up i cells from the tail.
  function automatic logic [63:0] model_chain(input vec_t v);
    logic [63:0] c;
    logic [7:0]  wd;
    int          len;
    c = '0;
    len = clen(v.k);
    for (int i = 0; i < len; i++) begin
      wd = v.w[i / 8];
      c[len - 1 - i] = wd[i % 8];
    end
    return c;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int   cyc, wi, gapc, base, len;
    bit   hold_ok, acc;
    logic last_head;
    len  = clen(v.k);
    base = shifts[v.k];
    start[v.k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[v.k] = 1'b0;
    cyc = 1;
    check({tag, " start_clears_count"}, 64'(bc(v.k)), 64'd0);
    check({tag, " start_clears_error"}, 64'(err[v.k]), 64'd0);
    wi = 0; gapc = 0; hold_ok = 1'b1; last_head = head[v.k];
    while (done[v.k] !== 1'b1 && cyc < 400) begin
      start[v.k] = (cyc == v.pulse_at);
      flip[v.k]  = (cyc == v.flip_at);
      valid[v.k] = (wi < 8) ? (gapc >= v.g[wi]) : 1'b0;
      data[v.k]  = (wi < 8) ? v.w[wi] : 8'($urandom_range(0, 255));
      acc = 1'b0;
      if (ready[v.k] === 1'b1) begin
        if (valid[v.k]) acc = 1'b1;
        else begin
          gapc++;
          if (sen[v.k] !== 1'b0 || head[v.k] !== last_head) hold_ok = 1'b0;
        end
      end
      last_head = head[v.k];
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc) begin
        wi++;
        gapc = 0;
      end
    end
    start[v.k] = 1'b0;
    flip[v.k]  = 1'b0;
    valid[v.k] = 1'b0;
    check({tag, " done_cycle"}, 64'(cyc), 64'(v.exp_cyc));
    check({tag, " bit_count"}, 64'(bc(v.k)), 64'(len));
    check({tag, " busy_at_done"}, 64'(busy[v.k]), 64'd0);
    check({tag, " error"}, 64'(err[v.k]), 64'(v.exp_err));
    check({tag, " shift_cycles"}, 64'(shifts[v.k] - base), 64'(VER ? 2 * len : len));
    check({tag, " hold_in_gap"}, 64'(hold_ok), 64'd1);
    if (v.flip_at == 0)
      check({tag, " chain"}, (v.k == 0) ? chain0 : 64'(chain1), model_chain(v));
    @(posedge clk);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done[v.k]), 64'd0);
    check({tag, " count_held"}, 64'(bc(v.k)), 64'(len));
  endtask

  vec_t tbl [5];
  vec_t rv;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; valid[k] = 1'b0; data[k] = '0; flip[k] = 1'b0;
    end
    for (int t = 0; t < 5; t++) begin
      tbl[t].k = 0; tbl[t].pulse_at = 0; tbl[t].flip_at = 0; tbl[t].exp_err = 1'b0;
      tbl[t].exp_cyc = 73 + (VER ? 64 : 0);
      for (int i = 0; i < 8; i++) begin
        tbl[t].w[i] = 8'(i + 1);
        tbl[t].g[i] = 0;
      end
    end
    tbl[1].g[3] = 3;
    tbl[1].exp_cyc = 76 + (VER ? 64 : 0);
    tbl[2].k = 1;
    tbl[2].w[0] = 8'hFF;
    tbl[2].w[1] = 8'hFD;
    tbl[2].exp_cyc = 13 + (VER ? 10 : 0);
    tbl[3].pulse_at = 20;
    tbl[4].flip_at = 90;
    tbl[4].exp_err = VER;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset%0d outputs", k),
            {58'd0, ready[k], head[k], sen[k], busy[k], done[k], err[k]}, 64'd0);
      check($sformatf("reset%0d bit_count", k), 64'(bc(k)), 64'd0);
      rst[k] = 1'b0;
    end

    for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Words offered while idle must be refused and leave the count alone.
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("idle_ready c%0d", i), 64'(ready[0]), 64'd0);
      check($sformatf("idle_shift c%0d", i), 64'(sen[0]), 64'd0);
      check($sformatf("idle_count c%0d", i), 64'(bc(0)), 64'd64);
    end

    // Reset in the middle of a load.
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    for (int n = 0; n < 200 && bc(0) != 20; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midreset reached_20", 64'(bc(0)), 64'd20);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    valid[0] = 1'b0;
    check("midreset outputs",
          {58'd0, ready[0], head[0], sen[0], busy[0], done[0], err[0]}, 64'd0);
    check("midreset bit_count", 64'(bc(0)), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("midreset no_done c%0d", i), 64'(done[0]), 64'd0);
    end
    run_vec(tbl[0], "after_reset");

    // Randomised loads against the reference model.
    for (int r = 0; r < 6; r++) begin
      rv.k = r % 2;
      rv.pulse_at = 0;
      rv.flip_at = 0;
      rv.exp_err = 1'b0;
      for (int i = 0; i < 8; i++) begin
        rv.w[i] = 8'($urandom_range(0, 255));
        rv.g[i] = $urandom_range(0, 3);
      end
      rv.exp_cyc = model_cycles(rv);
      run_vec(rv, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
